// File: rtl/ddc_agc_if.sv
// rtl/ddc_agc_if.sv - I/Q sample stream in and out of the AGC stage
interface ddc_agc_if #(
    parameter int DW = 14
);
    logic                 in_valid;
    logic signed [DW-1:0] i_in;
    logic signed [DW-1:0] q_in;
    logic                 out_valid;
    logic signed [DW-1:0] i_out;
    logic signed [DW-1:0] q_out;

    modport master (output in_valid, i_in, q_in, input out_valid, i_out, q_out);
    modport slave  (input in_valid, i_in, q_in, output out_valid, i_out, q_out);
endinterface

// File: rtl/ddc_agc.sv
// rtl/ddc_agc.sv - digital AGC: programmable gain with saturation, windowed envelope loop
module ddc_agc #(
    parameter int DW        = 14,
    parameter int WIN_LOG2  = 8,
    parameter int TARGET    = 4096,
    parameter int HYST      = 256,
    parameter int GAIN_INIT = 32
) (
    input  logic       clk,
    input  logic       reset,
    ddc_agc_if.slave   s,
    input  logic       agc_hold,
    output logic [7:0] gain_o,
    output logic       locked
);
    localparam int PW = DW + 9;
    localparam int MW = DW + 1;
    localparam int AW = WIN_LOG2 + DW + 1;
    localparam logic [AW-1:0]       HI_LIM  = AW'(TARGET + HYST);
    localparam logic [AW-1:0]       LO_LIM  = AW'(TARGET - HYST);
    localparam logic [WIN_LOG2-1:0] CNT_ONE = WIN_LOG2'(1);

    typedef enum logic {ACCUM, DECIDE} state_t;

    state_t               state_q, state_d;
    logic                 v1_q, v1_d;
    logic signed [PW-1:0] pi_q, pi_d, pq_q, pq_d;
    logic                 ov_q, ov_d;
    logic [DW-1:0]        io_q, io_d, qo_q, qo_d;
    logic [AW-1:0]        acc_q, acc_d, win_q, win_d;
    logic [WIN_LOG2-1:0]  cnt_q, cnt_d;
    logic [7:0]           g_q, g_d;
    logic [2:0]           inb_q, inb_d;
    logic                 locked_q, locked_d;

    logic signed [PW-1:0] xi_ext, xq_ext, g_ext;
    logic [MW-1:0]        m;
    logic [AW-1:0]        acc_sum, avg;

    // Floor shift by 5 (gain is Q3.5), then clamp to the DW-bit signed range.
    function automatic logic [DW-1:0] sat_shift(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] y;
        logic [PW-DW:0]       hi;
        y  = p >>> 5;
        hi = y[PW-1:DW-1];
        if (&hi || ~|hi) sat_shift = y[DW-1:0];
        else if (y[PW-1]) sat_shift = {1'b1, {(DW-1){1'b0}}};
        else sat_shift = {1'b0, {(DW-1){1'b1}}};
    endfunction

    // Unsigned magnitude; the most negative code maps to 2^(DW-1) exactly.
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] x);
        mag = x[DW-1] ? (~x) + DW'(1) : x;
    endfunction

    always_comb begin
        xi_ext  = {{9{s.i_in[DW-1]}}, s.i_in};
        xq_ext  = {{9{s.q_in[DW-1]}}, s.q_in};
        g_ext   = {{(PW-8){1'b0}}, g_q};
        m       = {1'b0, mag(io_q)} + {1'b0, mag(qo_q)};
        acc_sum = acc_q + {{(AW-MW){1'b0}}, m};
        avg     = win_q >> WIN_LOG2;

        v1_d     = s.in_valid;
        pi_d     = pi_q;
        pq_d     = pq_q;
        ov_d     = v1_q;
        io_d     = io_q;
        qo_d     = qo_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        state_d  = ACCUM;
        g_d      = g_q;
        inb_d    = inb_q;
        locked_d = locked_q;

        if (s.in_valid) begin
            pi_d = xi_ext * g_ext;
            pq_d = xq_ext * g_ext;
        end
        if (v1_q) begin
            io_d = sat_shift(pi_q);
            qo_d = sat_shift(pq_q);
        end

        if (ov_q) begin
            if (cnt_q == '1) begin
                win_d   = acc_sum;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = DECIDE;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // Lock tracking ignores agc_hold and clamping: only the measured level matters.
        if (state_q == DECIDE) begin
            if (avg > HI_LIM) begin
                inb_d = 3'd0;
                if (!agc_hold && g_q > 8'd1) g_d = g_q - 8'd1;
            end else if (avg < LO_LIM) begin
                inb_d = 3'd0;
                if (!agc_hold && g_q < 8'd255) g_d = g_q + 8'd1;
            end else begin
                inb_d = (inb_q == 3'd4) ? 3'd4 : inb_q + 3'd1;
            end
            locked_d = (inb_d == 3'd4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ACCUM;
            v1_q     <= 1'b0;
            pi_q     <= '0;
            pq_q     <= '0;
            ov_q     <= 1'b0;
            io_q     <= '0;
            qo_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            win_q    <= '0;
            g_q      <= 8'(GAIN_INIT);
            inb_q    <= 3'd0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            v1_q     <= v1_d;
            pi_q     <= pi_d;
            pq_q     <= pq_d;
            ov_q     <= ov_d;
            io_q     <= io_d;
            qo_q     <= qo_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            g_q      <= g_d;
            inb_q    <= inb_d;
            locked_q <= locked_d;
        end
    end

    assign s.out_valid = ov_q;
    assign s.i_out     = io_q;
    assign s.q_out     = qo_q;
    assign gain_o      = g_q;
    assign locked      = locked_q;
endmodule
